systolic_array_os: RTL and testbench

Output-stationary systolic MAC array with built-in input skewing, saturating accumulators and a row-by-row result drain. It generalises the earlier fixed, externally-skewed array. A tile of K input beats enters through one valid/ready port. The block computes C[r][c] = sum over k of Weight[r][k] * Act[c][k] and streams the ROWS result rows out through a second valid/ready port. It sits between the operand buffers and the result write-back path.

---
 rtl/systolic_array_os_if.sv | 37 +++
 rtl/systolic_array_os.sv | 214 +++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_os_if.sv
// Operand and result ports of the output-stationary systolic array.
// The operand side carries the tile start and one beat of activations
// and weights; the result side streams one accumulator row per handshake.
interface systolic_array_os_if #(
    parameter int DATA_N  = 8,
    parameter int ACC_N   = 24,
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int K_MAX   = 256
) ();
    localparam int K_N   = $clog2(K_MAX + 1);
    localparam int ROW_N = $clog2(ROWS);

    logic                       start;
    logic [K_N-1:0]             k_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [COLUMNS*DATA_N-1:0]  acts_in;
    logic [ROWS*DATA_N-1:0]     weights_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLUMNS*ACC_N-1:0]   out_data;
    logic [ROW_N-1:0]           out_row;
    logic                       out_last;
    logic                       out_sat;
    logic                       busy;

    modport slave (
        input  start, k_len, in_valid, acts_in, weights_in, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last, out_sat, busy
    );

    modport master (
        output start, k_len, in_valid, acts_in, weights_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last, out_sat, busy
    );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary systolic MAC array. Operands are skewed internally so
// that beat k of column c and row r meet at PE(r,c); each PE keeps a
// saturating accumulator that is drained one row per handshake.
// ROWS is assumed to be at least 2 (row 0 is final before FLUSH ends).
module systolic_array_os #(
    parameter int DATA_N  = 8,
    parameter int ACC_N   = 24,
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int K_MAX   = 256
) (
    input logic                clk,
    input logic                rst,
    systolic_array_os_if.slave bus
);
    localparam int K_N   = $clog2(K_MAX + 1);
    localparam int ROW_N = $clog2(ROWS);
    localparam int FL_N  = $clog2(ROWS + COLUMNS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [K_N-1:0]    k_len_q;
    logic [K_N-1:0]    beat_cnt;
    logic [FL_N-1:0]   flush_cnt;
    logic              in_fire;
    logic              acc_clear;
    logic              acc_enable;

    // Operand buses carry {valid, value}; the valid bit travels with the data.
    logic [DATA_N:0]          act_top  [COLUMNS];
    logic [DATA_N:0]          wgt_left [ROWS];
    logic [DATA_N:0]          act_o    [ROWS][COLUMNS];
    logic [DATA_N:0]          wgt_o    [ROWS][COLUMNS];
    logic signed [ACC_N-1:0]  acc_o    [ROWS][COLUMNS];
    logic                     sat_o    [ROWS][COLUMNS];

    logic [ROW_N-1:0]         sel_row;
    logic [COLUMNS*ACC_N-1:0] sel_data;
    logic                     sel_sat;

    assign in_fire      = bus.in_valid && (state == LOAD);
    assign acc_clear    = (state == IDLE) && bus.start;
    assign acc_enable   = (state == LOAD) || (state == FLUSH);
    assign bus.in_ready = (state == LOAD);
    assign bus.busy     = (state != IDLE);

    for (genvar c = 0; c < COLUMNS; c++) begin : g_act_skew
        logic [DATA_N:0] dly [c+1];
        // Delay activation column c by c extra cycles before it enters row 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= c; j++) dly[j] <= '0;
            end else begin
                dly[0] <= {in_fire, bus.acts_in[c*DATA_N +: DATA_N]};
                for (int j = 1; j <= c; j++) dly[j] <= dly[j-1];
            end
        end
        assign act_top[c] = dly[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_wgt_skew
        logic [DATA_N:0] dly [r+1];
        // Delay weight row r by r extra cycles before it enters column 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) dly[j] <= '0;
            end else begin
                dly[0] <= {in_fire, bus.weights_in[r*DATA_N +: DATA_N]};
                for (int j = 1; j <= r; j++) dly[j] <= dly[j-1];
            end
        end
        assign wgt_left[r] = dly[r];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLUMNS; c++) begin : g_pe
            logic [DATA_N:0]           a_in, w_in, a_q, w_q;
            logic signed [ACC_N-1:0]   acc_q, acc_nxt;
            logic                      sat_q, ovf;
            logic signed [2*DATA_N-1:0] prod;
            logic signed [ACC_N:0]     sum;

            if (r == 0) begin : g_a_top
                assign a_in = act_top[c];
            end else begin : g_a_pipe
                assign a_in = act_o[r-1][c];
            end
            if (c == 0) begin : g_w_left
                assign w_in = wgt_left[r];
            end else begin : g_w_pipe
                assign w_in = wgt_o[r][c-1];
            end

            assign prod = $signed(a_in[DATA_N-1:0]) * $signed(w_in[DATA_N-1:0]);
            assign sum  = $signed({acc_q[ACC_N-1], acc_q}) + $signed((ACC_N+1)'(prod));
            assign ovf  = sum[ACC_N] ^ sum[ACC_N-1];
            assign acc_nxt = !ovf       ? sum[ACC_N-1:0] :
                             sum[ACC_N] ? {1'b1, {(ACC_N-1){1'b0}}} :
                                          {1'b0, {(ACC_N-1){1'b1}}};

            // Pass operands on and accumulate with clamping when both are valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    w_q   <= '0;
                    acc_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    a_q <= a_in;
                    w_q <= w_in;
                    if (acc_clear) begin
                        acc_q <= '0;
                        sat_q <= 1'b0;
                    end else if (acc_enable && a_in[DATA_N] && w_in[DATA_N]) begin
                        acc_q <= acc_nxt;
                        sat_q <= sat_q | ovf;
                    end
                end
            end

            assign act_o[r][c] = a_q;
            assign wgt_o[r][c] = w_q;
            assign acc_o[r][c] = acc_q;
            assign sat_o[r][c] = sat_q;
        end
    end

    // Pick the accumulator row that the output register loads next.
    always_comb begin
        sel_row  = (state == DRAIN) ? bus.out_row + ROW_N'(1) : '0;
        sel_data = '0;
        sel_sat  = 1'b0;
        for (int c = 0; c < COLUMNS; c++) begin
            sel_data[c*ACC_N +: ACC_N] = acc_o[sel_row][c];
            sel_sat                    = sel_sat | sat_o[sel_row][c];
        end
    end

    // Tile sequencing: accept beats, let the wavefront drain, stream rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k_len_q       <= '0;
            beat_cnt      <= '0;
            flush_cnt     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k_len_q  <= bus.k_len;
                        beat_cnt <= '0;
                        if (bus.k_len == '0) begin
                            state         <= DRAIN;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= '0;
                            bus.out_row   <= '0;
                            bus.out_last  <= 1'b0;
                            bus.out_sat   <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        if (beat_cnt + 1'b1 == k_len_q) begin
                            state     <= FLUSH;
                            beat_cnt  <= '0;
                            flush_cnt <= FL_N'(ROWS + COLUMNS - 2);
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state         <= DRAIN;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= sel_data;
                        bus.out_row   <= '0;
                        bus.out_last  <= 1'b0;
                        bus.out_sat   <= sel_sat;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.out_data  <= '0;
                            bus.out_row   <= '0;
                            bus.out_last  <= 1'b0;
                            bus.out_sat   <= 1'b0;
                        end else begin
                            bus.out_row  <= sel_row;
                            bus.out_data <= sel_data;
                            bus.out_sat  <= sel_sat;
                            bus.out_last <= (sel_row == ROW_N'(ROWS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: two instances (24-bit and 16-bit accumulators)
// share one stimulus stream; a scoreboard queue per instance holds the
// hand-computed rows and a monitor pops them on every output handshake.
module tb_systolic_array_os;
    localparam int DN = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 256;
    localparam int KN = $clog2(KM + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start, in_valid, out_ready;
    logic [KN-1:0]   k_len;
    logic [C*DN-1:0] acts;
    logic [R*DN-1:0] wgts;

    systolic_array_os_if #(.DATA_N(DN), .ACC_N(24), .ROWS(R), .COLUMNS(C), .K_MAX(KM)) bus_a ();
    systolic_array_os_if #(.DATA_N(DN), .ACC_N(16), .ROWS(R), .COLUMNS(C), .K_MAX(KM)) bus_b ();

    systolic_array_os #(.DATA_N(DN), .ACC_N(24), .ROWS(R), .COLUMNS(C), .K_MAX(KM))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    systolic_array_os #(.DATA_N(DN), .ACC_N(16), .ROWS(R), .COLUMNS(C), .K_MAX(KM))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.start = start;       assign bus_b.start = start;
    assign bus_a.k_len = k_len;       assign bus_b.k_len = k_len;
    assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
    assign bus_a.acts_in = acts;      assign bus_b.acts_in = acts;
    assign bus_a.weights_in = wgts;   assign bus_b.weights_in = wgts;
    assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [3:0][31:0] v;
        logic [1:0]       row;
        logic             last;
        logic             sat;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [C*DN-1:0] beat_a [8];
    logic [R*DN-1:0] beat_w [8];

    bit               prev_stall [2];
    logic [3:0][31:0] prev_data  [2];
    logic [1:0]       prev_row   [2];
    bit               prev_last  [2];
    bit               prev_sat   [2];

    task automatic check_val(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic push_row(input int d, input int r, input int v0, input int v1,
                            input int v2, input int v3, input bit sat);
        exp_t e;
        e.v[0] = v0; e.v[1] = v1; e.v[2] = v2; e.v[3] = v3;
        e.row  = 2'(r);
        e.last = (r == R - 1);
        e.sat  = sat;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    function automatic logic [3:0][31:0] widen24(input logic [4*24-1:0] x);
        logic [3:0][31:0] y;
        for (int c = 0; c < 4; c++) y[c] = {{8{x[c*24+23]}}, x[c*24 +: 24]};
        return y;
    endfunction

    function automatic logic [3:0][31:0] widen16(input logic [4*16-1:0] x);
        logic [3:0][31:0] y;
        for (int c = 0; c < 4; c++) y[c] = {{16{x[c*16+15]}}, x[c*16 +: 16]};
        return y;
    endfunction

    task automatic check_output(input int d, input bit v, input bit rdy,
                                input logic [3:0][31:0] data, input logic [1:0] row,
                                input bit last, input bit sat);
        exp_t e;
        if (prev_stall[d]) begin
            total++;
            if (v && data == prev_data[d] && row == prev_row[d] &&
                last == prev_last[d] && sat == prev_sat[d]) passed++;
            else $display("[TB] FAIL stall_hold dut%0d: got valid=%0b row=%0d data=%h required valid=1 row=%0d data=%h",
                          d, v, row, data, prev_row[d], prev_data[d]);
        end
        if (v && rdy) begin
            total++;
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                $display("[TB] FAIL unexpected_row dut%0d: got row=%0d required no output", d, row);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (data == e.v && row == e.row && last == e.last && sat == e.sat) passed++;
                else $display("[TB] FAIL row_check dut%0d: got row=%0d last=%0b sat=%0b data=%0d,%0d,%0d,%0d required row=%0d last=%0b sat=%0b data=%0d,%0d,%0d,%0d",
                              d, row, last, sat, $signed(data[0]), $signed(data[1]), $signed(data[2]), $signed(data[3]),
                              e.row, e.last, e.sat, $signed(e.v[0]), $signed(e.v[1]), $signed(e.v[2]), $signed(e.v[3]));
            end
        end
        prev_stall[d] = v && !rdy;
        prev_data[d]  = data;
        prev_row[d]   = row;
        prev_last[d]  = last;
        prev_sat[d]   = sat;
    endtask

    // Monitor: sample both instances just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            check_output(0, bus_a.out_valid, out_ready, widen24(bus_a.out_data),
                         bus_a.out_row, bus_a.out_last, bus_a.out_sat);
            check_output(1, bus_b.out_valid, out_ready, widen16(bus_b.out_data),
                         bus_b.out_row, bus_b.out_last, bus_b.out_sat);
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_in_ready_a"},  bus_a.in_ready, 0);
        check_val({tag, "_out_valid_a"}, bus_a.out_valid, 0);
        check_val({tag, "_busy_a"},      bus_a.busy, 0);
        check_val({tag, "_out_data_a"},  |bus_a.out_data, 0);
        check_val({tag, "_out_row_a"},   bus_a.out_row, 0);
        check_val({tag, "_out_last_a"},  bus_a.out_last, 0);
        check_val({tag, "_out_sat_a"},   bus_a.out_sat, 0);
        check_val({tag, "_in_ready_b"},  bus_b.in_ready, 0);
        check_val({tag, "_out_valid_b"}, bus_b.out_valid, 0);
        check_val({tag, "_busy_b"},      bus_b.busy, 0);
        check_val({tag, "_out_data_b"},  |bus_b.out_data, 0);
    endtask

    task automatic wait_drain(input bit stall);
        int stall_cnt;
        bit tog;
        bit done;
        stall_cnt = 0;
        tog       = 1'b0;
        done      = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (!bus_a.busy) begin
                done = 1'b1;
            end else begin
                if (stall && bus_a.out_valid && bus_a.out_row == 2'd1 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    start = (stall_cnt == 3);
                    k_len = '0;
                end else if (stall && stall_cnt >= 5) begin
                    tog       = !tog;
                    out_ready = tog;
                    start     = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    start     = 1'b0;
                end
                @(negedge clk);
            end
        end
        check_val("drain_completes", done, 1);
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    task automatic apply_stimulus(input int k, input bit gaps, input bit stall);
        int ref_cyc;
        int exp_lat;
        int n;
        @(negedge clk);
        start   = 1'b1;
        k_len   = KN'(k);
        ref_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", bus_a.busy, 1);
        check_val("ready_after_start", bus_a.in_ready, k > 0);
        exp_lat = 1;
        for (int i = 0; i < k; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                check_val("ready_in_gap", bus_a.in_ready, 1);
            end
            in_valid = 1'b1;
            acts     = beat_a[i];
            wgts     = beat_w[i];
            ref_cyc  = cyc;
            @(negedge clk);
            check_val((i == k - 1) ? "ready_drop_after_last" : "ready_during_load",
                      bus_a.in_ready, i < k - 1);
        end
        in_valid = 1'b0;
        if (k > 0) exp_lat = R + C;
        n = 0;
        while (!bus_a.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("first_out_valid_latency", cyc - ref_cyc, exp_lat);
        wait_drain(stall);
    endtask

    task automatic fill_identity();
        for (int k = 0; k < 4; k++) begin
            beat_w[k] = '0;
            for (int c = 0; c < C; c++) beat_a[k][c*DN +: DN] = 8'(c + k);
            for (int r = 0; r < R; r++) beat_w[k][r*DN +: DN] = (r == k) ? 8'd1 : 8'd0;
        end
    endtask

    task automatic push_identity();
        for (int r = 0; r < R; r++) begin
            push_row(0, r, r, r + 1, r + 2, r + 3, 1'b0);
            push_row(1, r, r, r + 1, r + 2, r + 3, 1'b0);
        end
    endtask

    task automatic push_mix();
        for (int r = 0; r < R; r++) begin
            if (r % 2 == 0) begin
                push_row(0, r, 48642, -48768, 48642, -48768, 1'b0);
                push_row(1, r, 32767, -32768, 32767, -32768, 1'b1);
            end else begin
                push_row(0, r, -48768, 48897, -48768, 48897, 1'b0);
                push_row(1, r, -32768, 32767, -32768, 32767, 1'b1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion required finish");
        $fatal(1);
    end

    initial begin
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        k_len = '0; acts = '0; wgts = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        $display("[TB] identity weights, K=4");
        fill_identity();
        push_identity();
        apply_stimulus(4, 1'b0, 1'b0);

        $display("[TB] 127/-128 mix, K=3, gap-free then with gaps");
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < C; c++) beat_a[k][c*DN +: DN] = ((c + k) % 2 == 0) ? 8'h7f : 8'h80;
            for (int r = 0; r < R; r++) beat_w[k][r*DN +: DN] = ((r + k) % 2 == 0) ? 8'h7f : 8'h80;
        end
        push_mix();
        apply_stimulus(3, 1'b0, 1'b0);
        push_mix();
        apply_stimulus(3, 1'b1, 1'b0);

        $display("[TB] all 127, K=4");
        for (int k = 0; k < 4; k++) begin
            beat_a[k] = {C{8'h7f}};
            beat_w[k] = {R{8'h7f}};
        end
        for (int r = 0; r < R; r++) begin
            push_row(0, r, 64516, 64516, 64516, 64516, 1'b0);
            push_row(1, r, 32767, 32767, 32767, 32767, 1'b1);
        end
        apply_stimulus(4, 1'b0, 1'b0);

        $display("[TB] -128 x 127, K=4, stalled drain with Start pulse");
        for (int k = 0; k < 4; k++) begin
            beat_a[k] = {C{8'h80}};
            beat_w[k] = {R{8'h7f}};
        end
        for (int r = 0; r < R; r++) begin
            push_row(0, r, -65024, -65024, -65024, -65024, 1'b0);
            push_row(1, r, -32768, -32768, -32768, -32768, 1'b1);
        end
        apply_stimulus(4, 1'b0, 1'b1);

        $display("[TB] K=0 tile");
        for (int r = 0; r < R; r++) begin
            push_row(0, r, 0, 0, 0, 0, 1'b0);
            push_row(1, r, 0, 0, 0, 0, 1'b0);
        end
        apply_stimulus(0, 1'b0, 1'b0);

        $display("[TB] reset during LOAD after two beats");
        fill_identity();
        @(negedge clk);
        start = 1'b1;
        k_len = KN'(4);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            acts     = beat_a[i];
            wgts     = beat_w[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        push_identity();
        apply_stimulus(4, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check_val("scoreboard_empty_a", exp_q0.size(), 0);
        check_val("scoreboard_empty_b", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
